// File: rtl/conv_sequencer.sv
// Convolution pass sequencer: validates the configured memory window, streams
// read requests across it with round-robin engine selection, and posts status/IRQ.
module conv_sequencer #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned EngWidth  = 12
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [15:0]          mem_upper_i,
  input  logic [15:0]          mem_start_i,
  input  logic [15:0]          mem_end_i,
  input  logic [EngWidth-1:0]  engine_count_i,
  input  logic                 conv_intrr_en_i,
  input  logic                 intrr_clear_i,
  output logic [AddrWidth-1:0] rd_addr_o,
  output logic                 rd_valid_o,
  input  logic                 rd_ready_i,
  output logic [EngWidth-1:0]  eng_sel_o,
  output logic                 conv_done_o,
  output logic                 conv_running_o,
  output logic [4:0]           error_code_o,
  output logic                 we_int_o,
  output logic                 conv_intrr_ac_o,
  output logic                 we_int2_o,
  output logic                 irq_o
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StRun  = 1'b1;

  localparam logic [4:0] ErrOk    = 5'd0;
  localparam logic [4:0] ErrRange = 5'd1;
  localparam logic [4:0] ErrEng   = 5'd2;
  localparam logic [4:0] ErrAbort = 5'd3;

  logic [0:0]          state_q, state_d;
  logic [15:0]         upper_q, upper_d;
  logic [15:0]         offset_q, offset_d;
  logic [15:0]         end_q, end_d;
  logic [EngWidth-1:0] engcnt_q, engcnt_d;
  logic [EngWidth-1:0] eng_sel_q, eng_sel_d;
  logic                valid_q, valid_d;
  logic                done_q, done_d;
  logic                running_q, running_d;
  logic [4:0]          err_q, err_d;
  logic                we_int_q, we_int_d;
  logic                intrr_ac_q, intrr_ac_d;
  logic                we_int2_q, we_int2_d;
  logic                handshake;

  assign handshake = valid_q & rd_ready_i;

  always_comb begin
    state_d    = state_q;
    upper_d    = upper_q;
    offset_d   = offset_q;
    end_d      = end_q;
    engcnt_d   = engcnt_q;
    eng_sel_d  = eng_sel_q;
    valid_d    = valid_q;
    done_d     = done_q;
    running_d  = running_q;
    err_d      = err_q;
    we_int_d   = 1'b0;
    intrr_ac_d = intrr_ac_q;
    we_int2_d  = 1'b0;

    // Clear is evaluated first so that a completion in the same cycle overrides it.
    if (intrr_clear_i) begin
      intrr_ac_d = 1'b0;
      we_int2_d  = 1'b1;
    end

    case (state_q)
      StIdle: begin
        if (start_i) begin
          upper_d  = mem_upper_i;
          end_d    = mem_end_i;
          engcnt_d = engine_count_i;
          offset_d = mem_start_i;
          we_int_d = 1'b1;
          done_d   = 1'b0;
          if (mem_end_i < mem_start_i) begin
            err_d     = ErrRange;
            running_d = 1'b0;
          end else if (engine_count_i == '0) begin
            err_d     = ErrEng;
            running_d = 1'b0;
          end else begin
            state_d   = StRun;
            eng_sel_d = '0;
            valid_d   = 1'b1;
            running_d = 1'b1;
            err_d     = ErrOk;
          end
        end
      end
      StRun: begin
        if (abort_i) begin
          state_d   = StIdle;
          valid_d   = 1'b0;
          running_d = 1'b0;
          err_d     = ErrAbort;
          we_int_d  = 1'b1;
        end else if (handshake) begin
          if (offset_q == end_q) begin
            state_d   = StIdle;
            valid_d   = 1'b0;
            running_d = 1'b0;
            done_d    = 1'b1;
            we_int_d  = 1'b1;
            if (conv_intrr_en_i) begin
              intrr_ac_d = 1'b1;
              we_int2_d  = 1'b1;
            end
          end else begin
            offset_d  = offset_q + 16'd1;
            eng_sel_d = (eng_sel_q == engcnt_q - EngWidth'(1)) ? '0 : eng_sel_q + EngWidth'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      upper_q    <= '0;
      offset_q   <= '0;
      end_q      <= '0;
      engcnt_q   <= '0;
      eng_sel_q  <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      running_q  <= 1'b0;
      err_q      <= '0;
      we_int_q   <= 1'b0;
      intrr_ac_q <= 1'b0;
      we_int2_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      upper_q    <= upper_d;
      offset_q   <= offset_d;
      end_q      <= end_d;
      engcnt_q   <= engcnt_d;
      eng_sel_q  <= eng_sel_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      running_q  <= running_d;
      err_q      <= err_d;
      we_int_q   <= we_int_d;
      intrr_ac_q <= intrr_ac_d;
      we_int2_q  <= we_int2_d;
    end
  end

  assign rd_addr_o       = AddrWidth'({upper_q, offset_q});
  assign rd_valid_o      = valid_q;
  assign eng_sel_o       = eng_sel_q;
  assign conv_done_o     = done_q;
  assign conv_running_o  = running_q;
  assign error_code_o    = err_q;
  assign we_int_o        = we_int_q;
  assign conv_intrr_ac_o = intrr_ac_q;
  assign we_int2_o       = we_int2_q;
  assign irq_o           = intrr_ac_q & conv_intrr_en_i;

endmodule

// File: tb/tb_conv_sequencer.sv
// Directed bench for conv_sequencer: table of pass configurations plus
// hand-written abort, interrupt and reset-during-run sequences.
module tb_conv_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i, abort_i;
  logic [15:0] mem_upper_i, mem_start_i, mem_end_i;
  logic [11:0] engine_count_i;
  logic        conv_intrr_en_i, intrr_clear_i;
  logic [31:0] rd_addr_o;
  logic        rd_valid_o, rd_ready_i;
  logic [11:0] eng_sel_o;
  logic        conv_done_o, conv_running_o;
  logic [4:0]  error_code_o;
  logic        we_int_o, conv_intrr_ac_o, we_int2_o, irq_o;

  int total  = 0;
  int passed = 0;

  always #5 clk_i = ~clk_i;

  conv_sequencer #(.AddrWidth(32), .EngWidth(12)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
    .mem_upper_i(mem_upper_i), .mem_start_i(mem_start_i), .mem_end_i(mem_end_i),
    .engine_count_i(engine_count_i), .conv_intrr_en_i(conv_intrr_en_i),
    .intrr_clear_i(intrr_clear_i), .rd_addr_o(rd_addr_o), .rd_valid_o(rd_valid_o),
    .rd_ready_i(rd_ready_i), .eng_sel_o(eng_sel_o), .conv_done_o(conv_done_o),
    .conv_running_o(conv_running_o), .error_code_o(error_code_o), .we_int_o(we_int_o),
    .conv_intrr_ac_o(conv_intrr_ac_o), .we_int2_o(we_int2_o), .irq_o(irq_o)
  );

  typedef struct {
    logic [15:0] s;
    logic [15:0] e;
    logic [11:0] n;
    bit          toggle;
    bit          en;
    int          err;
    int          beats;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic do_reset();
    rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0; rd_ready_i = 1'b0;
    intrr_clear_i = 1'b0; conv_intrr_en_i = 1'b0;
    mem_upper_i = '0; mem_start_i = '0; mem_end_i = '0; engine_count_i = '0;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic start_pass(input logic [15:0] up, input logic [15:0] s,
                            input logic [15:0] e, input logic [11:0] n);
    mem_upper_i = up; mem_start_i = s; mem_end_i = e; engine_count_i = n;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    // Scramble the config inputs; the pass must use the latched copy.
    mem_upper_i = ~up; mem_start_i = 16'h0000; mem_end_i = 16'h0001; engine_count_i = 12'd7;
  endtask

  initial begin
    logic [15:0] up;
    int k, cyc;

    tbl[0] = '{s: 16'h0010, e: 16'h0013, n: 12'd3, toggle: 1'b0, en: 1'b1, err: 0, beats: 4};
    tbl[1] = '{s: 16'h0010, e: 16'h0013, n: 12'd3, toggle: 1'b1, en: 1'b0, err: 0, beats: 4};
    tbl[2] = '{s: 16'h0006, e: 16'h0005, n: 12'd3, toggle: 1'b0, en: 1'b0, err: 1, beats: 0};
    tbl[3] = '{s: 16'h0010, e: 16'h0013, n: 12'd0, toggle: 1'b0, en: 1'b0, err: 2, beats: 0};
    tbl[4] = '{s: 16'hFFFF, e: 16'hFFFF, n: 12'd2, toggle: 1'b0, en: 1'b0, err: 0, beats: 1};
    tbl[5] = '{s: 16'h0000, e: 16'h0002, n: 12'd1, toggle: 1'b1, en: 1'b1, err: 0, beats: 3};

    do_reset();
    check("rst_valid", {31'b0, rd_valid_o}, 32'd0);
    check("rst_addr", rd_addr_o, 32'd0);
    check("rst_eng", {20'b0, eng_sel_o}, 32'd0);
    check("rst_status", {conv_done_o, conv_running_o, we_int_o, conv_intrr_ac_o, we_int2_o, error_code_o}, 32'd0);

    for (int v = 0; v < 6; v++) begin
      do_reset();
      conv_intrr_en_i = tbl[v].en;
      up = 16'hA500 + 16'(v);
      start_pass(up, tbl[v].s, tbl[v].e, tbl[v].n);
      if (tbl[v].err != 0) begin
        check($sformatf("v%0d_err", v), {27'b0, error_code_o}, 32'(tbl[v].err));
        check($sformatf("v%0d_err_valid", v), {31'b0, rd_valid_o}, 32'd0);
        check($sformatf("v%0d_err_run", v), {31'b0, conv_running_o}, 32'd0);
        check($sformatf("v%0d_err_we", v), {31'b0, we_int_o}, 32'd1);
        @(negedge clk_i);
        check($sformatf("v%0d_err_we_end", v), {31'b0, we_int_o}, 32'd0);
        check($sformatf("v%0d_err_valid2", v), {31'b0, rd_valid_o}, 32'd0);
      end else begin
        check($sformatf("v%0d_run", v), {31'b0, conv_running_o}, 32'd1);
        k = 0; cyc = 0;
        while (k < tbl[v].beats && cyc < 200) begin
          rd_ready_i = tbl[v].toggle ? (cyc % 2 == 0) : 1'b1;
          check($sformatf("v%0d_valid_c%0d", v, cyc), {31'b0, rd_valid_o}, 32'd1);
          check($sformatf("v%0d_addr_c%0d", v, cyc), rd_addr_o, {up, 16'(tbl[v].s + 16'(k))});
          check($sformatf("v%0d_eng_c%0d", v, cyc), {20'b0, eng_sel_o}, 32'(k % int'(tbl[v].n)));
          check($sformatf("v%0d_we_c%0d", v, cyc), {31'b0, we_int_o}, (cyc == 0) ? 32'd1 : 32'd0);
          if (rd_ready_i) k++;
          cyc++;
          @(negedge clk_i);
        end
        rd_ready_i = 1'b0;
        check($sformatf("v%0d_beats", v), 32'(k), 32'(tbl[v].beats));
        if (!tbl[v].toggle) check($sformatf("v%0d_cycles", v), 32'(cyc), 32'(tbl[v].beats));
        check($sformatf("v%0d_end_valid", v), {31'b0, rd_valid_o}, 32'd0);
        check($sformatf("v%0d_done", v), {31'b0, conv_done_o}, 32'd1);
        check($sformatf("v%0d_done_we", v), {31'b0, we_int_o}, 32'd1);
        check($sformatf("v%0d_done_run", v), {31'b0, conv_running_o}, 32'd0);
        check($sformatf("v%0d_done_err", v), {27'b0, error_code_o}, 32'd0);
        check($sformatf("v%0d_intrr", v), {31'b0, conv_intrr_ac_o}, {31'b0, tbl[v].en});
        check($sformatf("v%0d_we2", v), {31'b0, we_int2_o}, {31'b0, tbl[v].en});
        check($sformatf("v%0d_irq", v), {31'b0, irq_o}, {31'b0, tbl[v].en});
        @(negedge clk_i);
        check($sformatf("v%0d_valid_after", v), {31'b0, rd_valid_o}, 32'd0);
        check($sformatf("v%0d_we_after", v), {31'b0, we_int_o}, 32'd0);
      end
    end

    // Abort on beat 2 of 8 while stalled, then restart, start-in-RUN, abort vs last beat.
    do_reset();
    start_pass(16'h0001, 16'h0100, 16'h0107, 12'd4);
    rd_ready_i = 1'b1;
    check("ab_addr0", rd_addr_o, 32'h0001_0100);
    @(negedge clk_i);
    rd_ready_i = 1'b0; abort_i = 1'b1;
    check("ab_addr1", rd_addr_o, 32'h0001_0101);
    check("ab_eng1", {20'b0, eng_sel_o}, 32'd1);
    @(negedge clk_i);
    abort_i = 1'b0;
    check("ab_valid", {31'b0, rd_valid_o}, 32'd0);
    check("ab_err", {27'b0, error_code_o}, 32'd3);
    check("ab_done", {31'b0, conv_done_o}, 32'd0);
    check("ab_run", {31'b0, conv_running_o}, 32'd0);
    check("ab_we", {31'b0, we_int_o}, 32'd1);
    @(negedge clk_i);
    check("ab_we_end", {31'b0, we_int_o}, 32'd0);
    start_pass(16'h0002, 16'h0200, 16'h0201, 12'd2);
    check("rs_err", {27'b0, error_code_o}, 32'd0);
    check("rs_valid", {31'b0, rd_valid_o}, 32'd1);
    rd_ready_i = 1'b1;
    start_i = 1'b1; mem_start_i = 16'h0009; mem_end_i = 16'h0003;
    @(negedge clk_i);
    start_i = 1'b0;
    check("rs_ignore_addr", rd_addr_o, 32'h0002_0201);
    check("rs_ignore_err", {27'b0, error_code_o}, 32'd0);
    abort_i = 1'b1;
    @(negedge clk_i);
    abort_i = 1'b0; rd_ready_i = 1'b0;
    check("ablast_err", {27'b0, error_code_o}, 32'd3);
    check("ablast_done", {31'b0, conv_done_o}, 32'd0);
    check("ablast_valid", {31'b0, rd_valid_o}, 32'd0);

    // Interrupt set, clear, enable gating, set-beats-clear.
    do_reset();
    conv_intrr_en_i = 1'b1;
    start_pass(16'h0000, 16'h0030, 16'h0030, 12'd1);
    rd_ready_i = 1'b1;
    @(negedge clk_i);
    rd_ready_i = 1'b0;
    check("irq_ac", {31'b0, conv_intrr_ac_o}, 32'd1);
    check("irq_we2", {31'b0, we_int2_o}, 32'd1);
    check("irq_out", {31'b0, irq_o}, 32'd1);
    @(negedge clk_i);
    check("irq_we2_end", {31'b0, we_int2_o}, 32'd0);
    conv_intrr_en_i = 1'b0;
    #1;
    check("irq_gated", {31'b0, irq_o}, 32'd0);
    check("irq_ac_hold", {31'b0, conv_intrr_ac_o}, 32'd1);
    conv_intrr_en_i = 1'b1;
    intrr_clear_i = 1'b1;
    @(negedge clk_i);
    intrr_clear_i = 1'b0;
    check("clr_ac", {31'b0, conv_intrr_ac_o}, 32'd0);
    check("clr_we2", {31'b0, we_int2_o}, 32'd1);
    check("clr_irq", {31'b0, irq_o}, 32'd0);
    start_pass(16'h0000, 16'h0040, 16'h0040, 12'd1);
    rd_ready_i = 1'b1; intrr_clear_i = 1'b1;
    @(negedge clk_i);
    rd_ready_i = 1'b0; intrr_clear_i = 1'b0;
    check("setclr_ac", {31'b0, conv_intrr_ac_o}, 32'd1);
    check("setclr_we2", {31'b0, we_int2_o}, 32'd1);

    // Reset in the middle of a pass.
    do_reset();
    conv_intrr_en_i = 1'b1;
    start_pass(16'h00FF, 16'h0010, 16'h0020, 12'd5);
    rd_ready_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0; rd_ready_i = 1'b0;
    check("mrst_valid", {31'b0, rd_valid_o}, 32'd0);
    check("mrst_addr", rd_addr_o, 32'd0);
    check("mrst_eng", {20'b0, eng_sel_o}, 32'd0);
    check("mrst_status", {conv_done_o, conv_running_o, we_int_o, conv_intrr_ac_o, we_int2_o, error_code_o}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
